aes_128_decrypt: RTL and testbench

Iterative AES-128 inverse cipher (FIPS-197 InvCipher), the decryption counterpart of the team's AES-128 encryption core. It accepts a 128-bit cipher key and a 128-bit ciphertext on a start pulse, runs the forward key schedule to recover the last round key, then executes the 10 inverse rounds while unrolling the key schedule backwards on the fly. It produces the plaintext with a one-cycle valid pulse. One round is computed per clock and no round-key storage is kept.

---
 rtl/aes_pkg.sv | 81 ++++++++
 rtl/aes_inv_round.sv | 50 +++++
 rtl/aes_128_decrypt.sv | 115 +++++++++++
 tb/tb_aes_128_decrypt.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES helpers: GF(2^8) math, S-boxes, Rcon and key-word functions.
// Also used by the AES-128 encryption core.
package aes_pkg;

  localparam int DATA_WIDTH = 128;
  localparam int KEY_WIDTH  = 128;
  localparam int RC_WIDTH   = 10;

  localparam logic [8*RC_WIDTH-1:0] RCON_TBL =
    80'h01_02_04_08_10_20_40_80_1b_36;

  typedef enum logic [1:0] {
    IDLE,
    KEY_EXP,
    ROUND
  } fsm_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse; maps 0 to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
             ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] b;
    b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]}
      ^ {a[1:0], a[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    int k;
    k = int'(i);
    if (k >= 1 && k <= RC_WIDTH)
      return RCON_TBL[8*(RC_WIDTH-k) +: 8];
    return 8'h00;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]), sbox(w[7:0])};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One AES inverse round, purely combinational.
// last suppresses InvMixColumns for the final round.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] state,
  input  logic [DATA_WIDTH-1:0] rk,
  input  logic                  last,
  output logic [DATA_WIDTH-1:0] next_state
);

  logic [DATA_WIDTH-1:0] sb;
  logic [DATA_WIDTH-1:0] ak;
  logic [DATA_WIDTH-1:0] mixed;

  // byte (r, c) comes from column c-r of the input
  always_comb begin
    sb = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sb[127-8*(r+4*c) -: 8] =
          inv_sbox(state[127-8*(r+4*((c-r+4)%4)) -: 8]);
      end
    end
  end

  assign ak = sb ^ rk;

  always_comb begin
    logic [7:0] a0, a1, a2, a3;
    mixed = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = ak[127-32*c -: 8];
      a1 = ak[119-32*c -: 8];
      a2 = ak[111-32*c -: 8];
      a3 = ak[103-32*c -: 8];
      mixed[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b)
                           ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      mixed[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e)
                           ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      mixed[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09)
                           ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      mixed[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d)
                           ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
  end

  assign next_state = last ? ak : mixed;

endmodule

// File: rtl/aes_128_decrypt.sv
// Iterative AES-128 inverse cipher, one round per clock.
// Key schedule runs forward to rk10, then backwards alongside rounds.
module aes_128_decrypt
  import aes_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_operation,
  input  logic [KEY_WIDTH-1:0]  key_vector,
  input  logic [DATA_WIDTH-1:0] cipher_text,
  output logic [DATA_WIDTH-1:0] plain_text,
  output logic                  data_valid,
  output logic                  busy
);

  fsm_t fsm, fsm_nxt;
  logic [3:0]            rc_cnt;
  logic [3:0]            rnd;
  logic [KEY_WIDTH-1:0]  key_reg;
  logic [DATA_WIDTH-1:0] state_reg;
  logic [DATA_WIDTH-1:0] round_out;

  function automatic logic [127:0] expand(
    input logic [127:0] k,
    input logic [7:0]   rc
  );
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sub_word(rot_word(k[31:0])) ^ {rc, 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] inv_expand(
    input logic [127:0] k,
    input logic [7:0]   rc
  );
    logic [31:0] w0, w1, w2, w3;
    w3 = k[31:0] ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    w0 = k[127:96] ^ sub_word(rot_word(w3)) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

  aes_inv_round u_round (
    .state      (state_reg),
    .rk         (key_reg),
    .last       (rnd == 4'd0),
    .next_state (round_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm <= IDLE;
    else        fsm <= fsm_nxt;
  end

  always_comb begin
    fsm_nxt = fsm;
    unique case (fsm)
      IDLE:    if (start_operation) fsm_nxt = KEY_EXP;
      KEY_EXP: if (rc_cnt == 4'(RC_WIDTH)) fsm_nxt = ROUND;
      ROUND:   if (rnd == 4'd0) fsm_nxt = IDLE;
      default: fsm_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (fsm != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_reg    <= '0;
      state_reg  <= '0;
      plain_text <= '0;
      data_valid <= 1'b0;
      rc_cnt     <= '0;
      rnd        <= '0;
    end else begin
      data_valid <= 1'b0;
      unique case (fsm)
        IDLE: begin
          if (start_operation) begin
            key_reg   <= key_vector;
            state_reg <= cipher_text;
            rc_cnt    <= 4'd1;
          end
        end
        KEY_EXP: begin
          key_reg <= expand(key_reg, rcon(rc_cnt));
          rc_cnt  <= rc_cnt + 4'd1;
          if (rc_cnt == 4'(RC_WIDTH)) rnd <= 4'(RC_WIDTH);
        end
        ROUND: begin
          if (rnd != 4'd0) begin
            rnd     <= rnd - 4'd1;
            key_reg <= inv_expand(key_reg, rcon(rnd));
          end
          unique case (1'b1)
            rnd == 4'(RC_WIDTH): state_reg <= state_reg ^ key_reg;
            rnd == 4'd0: begin
              plain_text <= round_out;
              data_valid <= 1'b1;
            end
            default: state_reg <= round_out;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_128_decrypt.sv
// Self-checking bench for aes_128_decrypt: FIPS vectors, corner cases
// and a round trip against an independent forward-cipher model.
module tb_aes_128_decrypt;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_operation = 1'b0;
  logic [127:0] key_vector = '0;
  logic [127:0] cipher_text = '0;
  logic [127:0] plain_text;
  logic         data_valid;
  logic         busy;

  always #5 clk = ~clk;

  aes_128_decrypt dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_operation (start_operation),
    .key_vector      (key_vector),
    .cipher_text     (cipher_text),
    .plain_text      (plain_text),
    .data_valid      (data_valid),
    .busy            (busy)
  );

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  typedef struct {
    logic [127:0] pt;
    time          t;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         checks = 0;
  int         failures = 0;
  int         n_valid = 0;
  int         exp_valid = 0;
  logic [7:0] sbt [256];

  task automatic chk(
    input string        name,
    input logic [127:0] act,
    input logic [127:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] tb_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] r;
    logic [7:0] x;
    logic [7:0] y;
    r = 0;
    x = a;
    y = b;
    while (y != 0) begin
      if (y[0]) r = r ^ x;
      x = (x << 1) ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return r;
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return tb_mul(a, 8'h02);
  endfunction

  function automatic logic [127:0] tb_encrypt(
    input logic [127:0] key,
    input logic [127:0] pt
  );
    logic [31:0]  w [44];
    logic [31:0]  x;
    logic [7:0]   rc;
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      x = w[i-1];
      if (i % 4 == 0) begin
        x = {sbt[x[23:16]], sbt[x[15:8]], sbt[x[7:0]], sbt[x[31:24]]}
          ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ x;
    end
    for (int i = 0; i < 16; i++)
      s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbt[s[i]];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++)
          s[q+4*c] = t[q+4*((c+q)%4)];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c];
          a1 = s[4*c+1];
          a2 = s[4*c+2];
          a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int i = 0; i < 16; i++)
        s[i] = s[i] ^ w[4*r+i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // scoreboard: every data_valid pops the oldest expectation
  always @(negedge clk) begin
    if (data_valid) begin
      n_valid++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: got pulse at %0t expected none",
                 $time);
      end else begin
        mon_e = sb.pop_front();
        chk("plain_text", plain_text, mon_e.pt);
        chk("valid_time", 128'($time), 128'(mon_e.t));
        chk("busy_at_valid", 128'(busy), 128'(0));
      end
    end
  end

  task automatic start_op(
    input logic [127:0] k,
    input logic [127:0] c,
    input logic [127:0] p
  );
    exp_t e;
    @(negedge clk);
    key_vector = k;
    cipher_text = c;
    start_operation = 1'b1;
    @(posedge clk);
    e.pt = p;
    e.t = $time + 215;
    sb.push_back(e);
    exp_valid++;
    #1;
    start_operation = 1'b0;
    key_vector = ~k;
    cipher_text = ~c;
    chk("busy_after_accept", 128'(busy), 128'(1));
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL timeout: pending %0d expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    vec_t         tbl [2];
    logic [7:0]   inv;
    logic [7:0]   b;
    logic [127:0] k;
    logic [127:0] p;
    logic [127:0] c;

    tbl[0] = '{128'h000102030405060708090a0b0c0d0e0f,
               128'h69c4e0d86a7b0430d8cdb78070b4c55a,
               128'h00112233445566778899aabbccddeeff};
    tbl[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
               128'h3925841d02dc09fbdc118597196a0b32,
               128'h3243f6a8885a308d313198a2e0370734};

    for (int x = 0; x < 256; x++) begin
      inv = 0;
      for (int y = 1; y < 256; y++)
        if (tb_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sbt[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
             ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end

    #12;
    chk("reset_plain_text", plain_text, 128'h0);
    chk("reset_data_valid", 128'(data_valid), 128'(0));
    chk("reset_busy", 128'(busy), 128'(0));
    rst_n = 1'b1;

    for (int i = 0; i < 2; i++) begin
      start_op(tbl[i].key, tbl[i].ct, tbl[i].pt);
      if (i == 1) begin
        repeat (10) @(posedge clk);
        #1;
        chk("key_reg_rk10", dut.key_reg,
            128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      end
      wait_done();
    end

    // starts while busy must be dropped
    start_op(tbl[0].key, tbl[0].ct, tbl[0].pt);
    repeat (4) @(negedge clk);
    key_vector = tbl[1].key;
    cipher_text = tbl[1].ct;
    start_operation = 1'b1;
    @(posedge clk);
    #1 start_operation = 1'b0;
    repeat (10) @(negedge clk);
    start_operation = 1'b1;
    @(posedge clk);
    #1 start_operation = 1'b0;
    wait_done();

    // second accept on the data_valid cycle of the first
    start_op(tbl[0].key, tbl[0].ct, tbl[0].pt);
    repeat (21) @(negedge clk);
    start_op(tbl[1].key, tbl[1].ct, tbl[1].pt);
    wait_done();

    // reset mid-run cancels the operation
    start_op(tbl[0].key, tbl[0].ct, tbl[0].pt);
    repeat (12) @(posedge clk);
    #1 rst_n = 1'b0;
    sb.delete();
    exp_valid--;
    #1;
    chk("midrst_plain_text", plain_text, 128'h0);
    chk("midrst_data_valid", 128'(data_valid), 128'(0));
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_key_reg", dut.key_reg, 128'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    start_op(tbl[0].key, tbl[0].ct, tbl[0].pt);
    wait_done();

    for (int i = 0; i < 1000; i++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      c = tb_encrypt(k, p);
      start_op(k, c, p);
      wait_done();
    end

    repeat (30) @(negedge clk);
    chk("valid_count", 128'(n_valid), 128'(exp_valid));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
